// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and divisor helper for the UART baud tick generator
package uart_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;

    // Rounded divisor in units of 1/2^frac_w g_clk cycles per oversample tick.
    // The result is {int, frac}: the low frac_w bits are the fraction.
    function automatic longint calc_divisor(input longint clk_hz, input longint baud,
                                            input longint os, input int frac_w);
        longint den;
        den = baud * os;
        return ((clk_hz << frac_w) + (den / 2)) / den;
    endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// rtl/uart_frac_divider.sv - fractional period counter producing the raw oversample tick
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              g_clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  int_eff;
    logic [DIV_W:0]    last;

    // Current period is div_int plus the carry out of the fractional accumulator;
    // the integer part is never allowed below 2 so a tick can never be back-to-back.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, div_frac};
        int_eff = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
        last    = {1'b0, int_eff} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]} - {{DIV_W{1'b0}}, 1'b1};
    end

    assign tick = !clear && ({1'b0, cnt} == last);

    // Count 0..P-1; on the last count restart and advance the fractional phase.
    always_ff @(posedge g_clk) begin
        if (rst || clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (tick) begin
            cnt <= '0;
            acc <= acc_sum[FRAC_W-1:0];
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// rtl/uart_baud_tick_gen.sv - UART baud generator emitting rx/tx/mid-bit enable ticks
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int DEF_BAUD   = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic              g_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pending,
    output logic              div_err,
    input  logic              rx_resync,
    output logic              rx_tick,
    output logic              rx_mid,
    output logic              tx_tick
);

    localparam int                OS_W     = $clog2(OVERSAMPLE);
    localparam longint            DEF_DIV  = calc_divisor(longint'(CLK_FREQ), longint'(DEF_BAUD),
                                                          longint'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic [OS_W-1:0]   os_cnt;
    logic              raw_tick;
    logic              clear;
    logic              os_wrap;
    logic              os_half;
    logic              apply;
    logic              load_bad;

    // Disable and resync both restart the bit phase from zero; resync also swallows a due tick.
    assign clear    = !enable || rx_resync;
    assign os_wrap  = raw_tick && (os_cnt == OS_LAST);
    assign os_half  = raw_tick && (os_cnt == OS_HALF);
    // A new divisor only takes effect on a bit boundary, or whenever the phase is being reset anyway.
    assign apply    = div_pending && (clear || os_wrap);
    assign load_bad = div_int < DIV_W'(2);

    uart_frac_divider #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .g_clk    (g_clk),
        .rst      (rst),
        .clear    (clear),
        .div_int  (act_int),
        .div_frac (act_frac),
        .tick     (raw_tick)
    );

    // Oversample position counter and registered tick strobes.
    always_ff @(posedge g_clk) begin
        if (rst) begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
            rx_mid  <= 1'b0;
            os_cnt  <= '0;
        end else begin
            rx_tick <= raw_tick;
            tx_tick <= os_wrap;
            rx_mid  <= os_half;
            if (clear) begin
                os_cnt <= '0;
            end else if (raw_tick) begin
                os_cnt <= os_cnt + OS_W'(1);
            end
        end
    end

    // Divisor capture into the pending slot and hand-over to the active divisor.
    always_ff @(posedge g_clk) begin
        if (rst) begin
            act_int     <= DEF_INT;
            act_frac    <= DEF_FRAC;
            pend_int    <= '0;
            pend_frac   <= '0;
            div_pending <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            if (apply) begin
                act_int  <= pend_int;
                act_frac <= pend_frac;
            end
            if (div_load) begin
                pend_int    <= load_bad ? DIV_W'(2) : div_int;
                pend_frac   <= div_frac;
                div_pending <= 1'b1;
                div_err     <= load_bad;
            end else if (apply) begin
                div_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_baud_tick_gen.md
Name: uart_baud_tick_gen

Overview:
- Next-generation UART baud generator, replacing derived t_clk/r_clk outputs with single-cycle enable ticks in the g_clk domain.
- Runtime-programmable fractional divisor (integer + FRAC_W-bit fraction) and a parametrised oversample ratio.
- Receiver phase resync on start-bit detection, plus a mid-bit sample strobe.
- Sits between the UART register block (divisor writes) and the TX/RX shift engines (tick consumers).

Parameters:
- CLK_FREQ, 10_000_000, g_clk frequency in Hz (elaboration only).
- DEF_BAUD, 115200, baud rate loaded at reset.
- OVERSAMPLE, 16, rx_tick pulses per bit; power of two, 4..64.
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor.

Ports:
- g_clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, generator run; low clears phase, no ticks.
- div_int, in, DIV_W, integer part of g_clk cycles per rx_tick.
- div_frac, in, FRAC_W, fractional part in units of 1/2^FRAC_W.
- div_load, in, 1, one-cycle strobe; captures div_int/div_frac.
- div_pending, out, 1, captured divisor not yet applied.
- div_err, out, 1, sticky; last load had div_int<2 (clamped).
- rx_resync, in, 1, restart bit phase (receiver start-edge).
- rx_tick, out, 1, oversample tick, 1 cycle.
- rx_mid, out, 1, mid-bit strobe, coincident with an rx_tick.
- tx_tick, out, 1, bit-rate tick, coincident with an rx_tick.

Behaviour:
- One clock: g_clk. Reset is synchronous, active-high, named rst.
- Reset values:
  - all tick outputs 0; div_pending 0; div_err 0.
  - cnt, acc and os_cnt are 0.
  - Active divisor = round(CLK_FREQ*2^FRAC_W/(DEF_BAUD*OVERSAMPLE)). Defaults give 87, i.e. int 5, frac 7.
- Period generation:
  - cnt counts 0..P-1.
  - At cnt==P-1: cnt←0, acc←(acc+frac) mod 2^FRAC_W, rx_tick registered high for the next cycle.
  - P = div_int + carry(acc+frac).
  - Over any 2^FRAC_W consecutive rx_ticks, exactly frac periods are extended by one cycle.
- Latency: with enable high from cycle 0, the first rx_tick is visible at cycle P0, where P0 = div_int + carry(0+frac).
- os_cnt (log2 OVERSAMPLE bits) increments on each internal tick and wraps.
  - tx_tick is asserted with the rx_tick on which os_cnt wraps OVERSAMPLE-1→0.
  - rx_mid is asserted with the rx_tick on which os_cnt goes OVERSAMPLE/2-1→OVERSAMPLE/2.
- Divisor load:
  - div_load captures div_int/div_frac into pending registers and sets div_pending.
  - div_int<2 is clamped to 2 and sets div_err. div_err is cleared only by rst or by a valid load.
  - The pending value becomes active at the next tx_tick boundary; div_pending clears the same cycle.
  - If enable is low, the pending value is applied on the next cycle.
  - A second div_load while pending overwrites the pending value.
- enable low: cnt, acc and os_cnt forced to 0; ticks 0. Load capture still operates.
- rx_resync: next edge forces cnt, acc, os_cnt to 0.
  - No tick is emitted that cycle, even if one was due: resync wins.
  - The first rx_mid after resync arrives (OVERSAMPLE/2)·P cycles later.
  - A pending divisor is applied at resync.
- Simultaneous rst with anything: rst wins.

Decomposition:
- Package uart_pkg:
  - DIV_W and FRAC_W defaults.
  - Function calc_divisor(clk, baud, os) returning {int, frac} with rounding; shared by the bench for expected values.
- Sub-module uart_frac_divider: cnt + acc + clamp; outputs the raw tick.
- Top: os_cnt, tick decode, load/pending logic.

Test Plan:
- Reset defaults: rst 3 cycles, enable=1 → first rx_tick at cycle 5; 16 rx_ticks span exactly 87 cycles; tx_tick on the 16th; rx_mid on the 8th.
- Integer divisor: load int=10, frac=0 → rx_tick period exactly 10; tx_tick period 160; div_pending high until the first tx_tick after load.
- Fractional accumulation: int=5, frac=8 → periods alternate 5,6 starting with 5; 32 rx_ticks = 176 cycles.
- Clamp: load int=1 → div_err=1, period 2. Then load int=4 → div_err=0, period 4 after the next tx_tick.
- Resync mid-bit: pulse rx_resync when os_cnt=5, including the cycle a tick is due → tick suppressed; rx_mid exactly 8·P cycles later; tx_tick 16·P later.
- Enable drop: deassert enable mid-period for 20 cycles → no ticks; on re-enable the first rx_tick is P0 cycles later. Reset asserted mid-operation → all outputs 0 next cycle; default divisor restored.
